// File: rtl/s2f_pkg.sv
// Shared types and constants for the slow-to-fast word receiver.
package s2f_pkg;

    // Width of the warm-up / settle counter; bounds SETTLE and SYNC_STAGES to 0..15.
    localparam int S2F_CNT_W = 4;

    // Receiver control states.
    typedef enum logic [1:0] {
        ST_WARM   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SETTLE = 2'd2
    } s2f_state_t;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset to 0.
// Generic enough to be reused for any level signal entering a clock domain.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/slow_to_fast_sync.sv
// Fast-domain receiver for an N-bit word launched on slow_clk.
// slow_clk is synchronized as data; its rising edge starts a settle delay,
// after which d is captured into q with a one-cycle q_valid strobe.
// Optional feature macro: S2F_OVERRUN_DET_EN (re-arm on early edge + sticky overrun).
module slow_to_fast_sync
    import s2f_pkg::*;
#(
    parameter int N           = 12,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 1
) (
    input  logic         fast_clk,
    input  logic         reset,
    input  logic         slow_clk,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         q_valid,
    output logic         overrun
);

    localparam logic [S2F_CNT_W-1:0] WARM_CNT   = S2F_CNT_W'(SYNC_STAGES);
    localparam logic [S2F_CNT_W-1:0] SETTLE_CNT = S2F_CNT_W'(SETTLE);
    localparam logic [S2F_CNT_W-1:0] CNT_ZERO   = {S2F_CNT_W{1'b0}};
    localparam logic [S2F_CNT_W-1:0] CNT_ONE    = {{(S2F_CNT_W-1){1'b0}}, 1'b1};

    logic                 sync_out_s;
    logic                 rise_s;
    logic                 prev_q;
    s2f_state_t           state_q, state_d;
    logic [S2F_CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]         word_q, word_d;
    logic                 valid_q, valid_d;
`ifdef S2F_OVERRUN_DET_EN
    logic                 ovr_q, ovr_d;
`endif

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_slow_clk (
        .clk_i (fast_clk),
        .rst_i (reset),
        .d_i   (slow_clk),
        .q_o   (sync_out_s)
    );

    assign rise_s = sync_out_s & ~prev_q;

    // Next-state logic: warm-up hold-off, edge wait, settle countdown and capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
`ifdef S2F_OVERRUN_DET_EN
        ovr_d   = ovr_q;
`endif
        case (state_q)
            ST_WARM: begin
                // Edges are ignored here so a slow_clk already high at reset
                // release is not mistaken for a fresh launch.
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (rise_s) begin
                    if (SETTLE == 0) begin
                        word_d  = d;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d   = SETTLE_CNT;
                        state_d = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
`ifdef S2F_OVERRUN_DET_EN
                // An early edge restarts the wait so the newest word wins.
                if (rise_s) begin
                    cnt_d = SETTLE_CNT;
                    ovr_d = 1'b1;
                end else if (cnt_q == CNT_ONE) begin
`else
                // An early edge is ignored; the pending capture completes.
                if (cnt_q == CNT_ONE) begin
`endif
                    cnt_d   = CNT_ZERO;
                    word_d  = d;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                cnt_d   = WARM_CNT;
                state_d = ST_WARM;
            end
        endcase
    end

    // State, counter, edge-history and output registers.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WARM;
            cnt_q   <= WARM_CNT;
            prev_q  <= 1'b0;
            word_q  <= {N{1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= sync_out_s;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

`ifdef S2F_OVERRUN_DET_EN
    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

    assign q       = word_q;
    assign q_valid = valid_q;

endmodule

// File: tb/tb_slow_to_fast_sync.sv
// Directed bench for slow_to_fast_sync. Three instances (SETTLE = 0, 1, 3)
// share one stimulus. Inputs change on the falling fast_clk edge; with two
// synchronizer stages a slow_clk rise driven there makes rise high in the
// cycle after the 2nd following posedge (R), so the strobe for SETTLE=s is
// seen after posedge number 3+s.
module tb_slow_to_fast_sync;

    localparam int W = 12;
`ifdef S2F_OVERRUN_DET_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic         fast_clk;
    logic         reset;
    logic         slow_clk;
    logic [W-1:0] d;
    logic [W-1:0] q0, q1, q3;
    logic         v0, v1, v3;
    logic         o0, o1, o3;
    logic [W-1:0] eq0, eq1, eq3;
    int           errors;
    int           checks;

    slow_to_fast_sync #(.N(W), .SYNC_STAGES(2), .SETTLE(0)) u_s0 (
        .fast_clk(fast_clk), .reset(reset), .slow_clk(slow_clk), .d(d),
        .q(q0), .q_valid(v0), .overrun(o0));
    slow_to_fast_sync #(.N(W), .SYNC_STAGES(2), .SETTLE(1)) u_s1 (
        .fast_clk(fast_clk), .reset(reset), .slow_clk(slow_clk), .d(d),
        .q(q1), .q_valid(v1), .overrun(o1));
    slow_to_fast_sync #(.N(W), .SYNC_STAGES(2), .SETTLE(3)) u_s3 (
        .fast_clk(fast_clk), .reset(reset), .slow_clk(slow_clk), .d(d),
        .q(q3), .q_valid(v3), .overrun(o3));

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge fast_clk);
        @(negedge fast_clk);
    endtask

    task automatic chk_quiet(input string tag, input int k);
        chk({tag, "_valid"}, k, {29'd0, v0, v1, v3}, 32'd0);
        chk({tag, "_q0"}, k, {20'd0, q0}, {20'd0, eq0});
        chk({tag, "_q1"}, k, {20'd0, q1}, {20'd0, eq1});
        chk({tag, "_q3"}, k, {20'd0, q3}, {20'd0, eq3});
    endtask

    // One slow period of 10 fast cycles: rise carrying w, fall halfway.
    task automatic pulse(input logic [W-1:0] w);
        d        = w;
        slow_clk = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("p_v0", k, {31'd0, v0}, {31'd0, (k == 3)});
            chk("p_v1", k, {31'd0, v1}, {31'd0, (k == 4)});
            chk("p_v3", k, {31'd0, v3}, {31'd0, (k == 6)});
            chk("p_q0", k, {20'd0, q0}, {20'd0, ((k >= 3) ? w : eq0)});
            chk("p_q1", k, {20'd0, q1}, {20'd0, ((k >= 4) ? w : eq1)});
            chk("p_q3", k, {20'd0, q3}, {20'd0, ((k >= 6) ? w : eq3)});
            chk("p_ovr", k, {29'd0, o0, o1, o3}, 32'd0);
            if (k == 5) slow_clk = 1'b0;
        end
        eq0 = w;
        eq1 = w;
        eq3 = w;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        slow_clk = 1'b0;
        d        = 12'h000;
        eq0      = 12'h000;
        eq1      = 12'h000;
        eq3      = 12'h000;

        // Reset state.
        step();
        step();
        chk_quiet("rst", 0);
        chk("rst_ovr", 0, {29'd0, o0, o1, o3}, 32'd0);

        // Release reset; the first rise lands in the first IDLE cycle after WARM.
        reset = 1'b0;
        step();
        pulse(12'h5A3);
        pulse(12'h5A3);
        pulse(12'h5A3);

        // Incrementing words, one capture each.
        for (int i = 0; i < 16; i++) begin
            pulse(12'(i));
        end

        // slow_clk high through reset release: no capture until a genuine rise.
        d        = 12'h7E1;
        slow_clk = 1'b1;
        reset    = 1'b1;
        eq0      = 12'h000;
        eq1      = 12'h000;
        eq3      = 12'h000;
        #1;
        chk_quiet("hi_rst", 0);
        step();
        step();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_quiet("hi_warm", k);
        end
        slow_clk = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_quiet("hi_low", k);
        end
        pulse(12'h3C4);

        // Reset during SETTLE of the SETTLE=3 instance aborts its capture.
        d        = 12'h6B2;
        slow_clk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("ab_v3", k, {31'd0, v3}, 32'd0);
            chk("ab_q3", k, {20'd0, q3}, {20'd0, eq3});
        end
        reset = 1'b1;
        eq0   = 12'h000;
        eq1   = 12'h000;
        eq3   = 12'h000;
        #1;
        chk_quiet("ab_rst", 0);
        step();
        step();
        slow_clk = 1'b0;
        reset    = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_quiet("ab_after", k);
        end
        pulse(12'h2D9);

        // Two slow rises 2 fast cycles apart. SETTLE=3 sees the second rise
        // mid-settle: with detection it re-arms (strobe 2 cycles later, overrun
        // set); without it the first deadline stands. d already carries the
        // second word at both deadlines, so every instance ends holding it.
        d        = 12'h111;
        slow_clk = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("or_v0", k, {31'd0, v0}, {31'd0, (k == 3 || k == 5)});
            chk("or_v1", k, {31'd0, v1}, {31'd0, (k == 4 || k == 6)});
            chk("or_v3", k, {31'd0, v3}, {31'd0, (OVR_EN ? (k == 8) : (k == 6))});
            chk("or_o01", k, {30'd0, o0, o1}, 32'd0);
            chk("or_o3", k, {31'd0, o3}, {31'd0, (OVR_EN && (k >= 5))});
            if (k == 5) chk("or_q3_hold", k, {20'd0, q3}, {20'd0, 12'h2D9});
            if (k == 1) slow_clk = 1'b0;
            if (k == 2) begin
                d        = 12'h222;
                slow_clk = 1'b1;
            end
            if (k == 3) slow_clk = 1'b0;
        end
        chk("or_q0", 0, {20'd0, q0}, {20'd0, 12'h222});
        chk("or_q1", 0, {20'd0, q1}, {20'd0, 12'h222});
        chk("or_q3", 0, {20'd0, q3}, {20'd0, 12'h222});
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("or_sticky", k, {31'd0, o3}, {31'd0, OVR_EN});
            chk("or_quiet", k, {29'd0, v0, v1, v3}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
